pc_flow_ctrl: RTL
=================

// Module: pc_flow_ctrl
// PURPOSE
//  Pipeline flow controller that sequences the program counter register.
//  Arbitrates EX-stage redirects (JAL, JALR, taken branch), ID-stage load-use stalls and multi-cycle
//  FFT/IFFT accelerator instructions; drives pc_we/pc_next and IF/ID, ID/EX flush/stall controls.
//  Sits between decode/execute hazard sources and the PC register; the PC register only loads pc_next when pc_we=1.
// PARAMETERS
//  XLEN          32        PC / operand width
//  RESET_PC      32'h0     PC value presented after reset
//  FLUSH_CYCLES  2         bubble cycles inserted after a redirect (1..3)
//  ACC_TIMEOUT   1024      max accelerator wait cycles before forced release
// PORTS
//  clk           in   1     clock, rising edge
//  rst           in   1     synchronous reset, active-high
//  cur_pc        in   XLEN  current PC register value
//  jump          in   2     EX jump type: 00 none, 01 JAL, 10 JALR
//  branch        in   1     EX instruction is a conditional branch
//  zero          in   1     EX ALU branch condition true
//  jal_target    in   XLEN  ex_pc + imm
//  jalr_target   in   XLEN  rs1 + imm (bit0 cleared here)
//  br_target     in   XLEN  ex_pc + imm for branches
//  ld_use        in   1     ID load-use hazard
//  acc_start     in   1     EX holds FFT/IFFT custom instruction
//  acc_done      in   1     accelerator finished (pulse or level)
//  pc_we         out  1     PC register load enable
//  pc_next       out  XLEN  value PC register loads
//  flush_ifid    out  1     clear IF/ID register to NOP
//  flush_idex    out  1     clear ID/EX register to NOP
//  stall_ifid    out  1     hold IF/ID register
//  acc_busy      out  1     accelerator wait in progress
//  acc_timeout   out  1     sticky: accelerator wait timed out; cleared by rst
// BEHAVIOUR
//  - Reset (rst=1 at clk edge): state=RUN, counters=0, acc_timeout=0; all registered outputs 0.
//    pc_we=1, pc_next=RESET_PC in the first cycle after reset is released.
//  - States: RUN, FLUSH, ACC_WAIT. Outputs combinational from state + inputs; state/counters registered.
//  - RUN, priority high->low:
//    1 jump=01: pc_next=jal_target; jump=10: pc_next=jalr_target&~1; jump=11 treated as none.
//    2 branch&zero: pc_next=br_target.
//      Redirect (1 or 2): pc_we=1, flush_ifid=flush_idex=1, cnt<=FLUSH_CYCLES-1, go FLUSH (stay RUN if FLUSH_CYCLES=1).
//    3 acc_start: pc_we=0, stall_ifid=1, flush_idex=1 (bubble), wcnt<=0, go ACC_WAIT.
//    4 ld_use: pc_we=0, stall_ifid=1, flush_idex=1 for exactly the cycle ld_use=1.
//    5 else pc_we=1, pc_next=cur_pc+4 (modulo 2^XLEN, wraps 0xFFFF_FFFC -> 0).
//  - FLUSH: pc_we=1, pc_next=cur_pc+4, flush_ifid=flush_idex=1; cnt decrements; at cnt=0 go RUN.
//    jump/branch/acc_start/ld_use ignored in FLUSH (they belong to squashed instructions).
//  - ACC_WAIT: acc_busy=1, pc_we=0, stall_ifid=1, flush_idex=1; wcnt increments each cycle.
//    acc_done=1 -> next cycle RUN with pc_we=1 (acc_done sampled same cycle as entry is ignored).
//    wcnt==ACC_TIMEOUT-1 without acc_done -> set acc_timeout, go RUN.
//    Redirect inputs ignored in ACC_WAIT (EX is frozen on the accelerator instruction).
//  - Simultaneous redirect + ld_use/acc_start in RUN: redirect wins, younger hazards squashed.
//  - rst asserted mid-FLUSH or mid-ACC_WAIT: immediate return to RUN per reset rule; no partial flush resumes.
//  - Exactly one of {pc_we, stall_ifid} is 1 every non-reset cycle.
// STRUCTURE
//  - Shared package/define file: jump encodings (JUMP_NONE/JAL/JALR), state encodings, funEnable/funDisable.
//  - One sub-module: pc_flow_wait_cnt (loadable down/up counter with terminal flag) used for cnt and wcnt.
//  - Next-PC mux and priority logic stay in this module; PC register itself remains external.
// TESTING
//  1 Reset: rst=1 two cycles, release -> pc_we=1, pc_next=0, flushes 0, acc_busy=0.
//  2 JAL: cur_pc=0x40, jump=01, jal_target=0x100 -> pc_next=0x100, flush_ifid/idex=1 for 2 cycles.
//  3 JALR bit0 + same-cycle ld_use: jalr_target=0x203 -> pc_next=0x202, stall_ifid=0.
//  4 Load-use: ld_use=1 one cycle at cur_pc=0x80 -> pc_we=0, stall_ifid=1, flush_idex=1; next cycle pc_next=0x84.
//  5 Accelerator: acc_start, acc_done after 37 cycles -> acc_busy=1 for 37 cycles, then pc_we=1; ACC_TIMEOUT=8, no done -> acc_timeout=1 after 8.
//  6 Wrap + mid-op reset: cur_pc=0xFFFF_FFFC -> pc_next=0; rst during ACC_WAIT -> acc_busy=0 next cycle.

Source files
------------

// File: rtl/pc_flow_ctrl_pkg.sv
// pc_flow_ctrl_pkg
//   Shared definitions for the PC flow controller.
//   - jump_e     : EX-stage jump encodings carried on the 2-bit jump bus
//   - state_e    : flow controller states
//   - funEnable / funDisable : readable names for single-bit enables
package pc_flow_ctrl_pkg;

   typedef enum logic [1:0] {
      JUMP_NONE = 2'b00,
      JUMP_JAL  = 2'b01,
      JUMP_JALR = 2'b10
   } jump_e;

   typedef enum logic [1:0] {
      RUN      = 2'b00,
      FLUSH    = 2'b01,
      ACC_WAIT = 2'b10
   } state_e;

   localparam logic funEnable  = 1'b1;
   localparam logic funDisable = 1'b0;

endpackage

// File: rtl/pc_flow_ctrl_if.sv
// pc_flow_ctrl_if
//   Bundles the hazard / redirect inputs and the PC + pipeline control
//   outputs of the flow controller.
//   Modports:
//     slave  : the flow controller (consumes hazards, drives controls)
//     master : the pipeline side (drives hazards, consumes controls)
//   Signals: cur_pc, jump, branch, zero, jal_target, jalr_target, br_target,
//            ld_use, acc_start, acc_done  (pipeline -> controller)
//            pc_we, pc_next, flush_ifid, flush_idex, stall_ifid, acc_busy,
//            acc_timeout                  (controller -> pipeline)
interface pc_flow_ctrl_if #(
   parameter int XLEN = 32
);
   logic [XLEN-1:0] cur_pc;
   logic [1:0]      jump;
   logic            branch;
   logic            zero;
   logic [XLEN-1:0] jal_target;
   logic [XLEN-1:0] jalr_target;
   logic [XLEN-1:0] br_target;
   logic            ld_use;
   logic            acc_start;
   logic            acc_done;

   logic            pc_we;
   logic [XLEN-1:0] pc_next;
   logic            flush_ifid;
   logic            flush_idex;
   logic            stall_ifid;
   logic            acc_busy;
   logic            acc_timeout;

   modport slave (
      input  cur_pc, jump, branch, zero, jal_target, jalr_target, br_target,
             ld_use, acc_start, acc_done,
      output pc_we, pc_next, flush_ifid, flush_idex, stall_ifid, acc_busy,
             acc_timeout
   );

   modport master (
      output cur_pc, jump, branch, zero, jal_target, jalr_target, br_target,
             ld_use, acc_start, acc_done,
      input  pc_we, pc_next, flush_ifid, flush_idex, stall_ifid, acc_busy,
             acc_timeout
   );
endinterface

// File: rtl/pc_flow_wait_cnt.sv
// pc_flow_wait_cnt
//   Loadable up/down counter with a terminal flag.
//   Ports:
//     clk, rst  : clock, synchronous active-high reset (count -> 0)
//     load      : load load_val this cycle (wins over en)
//     load_val  : value to load
//     en        : count this cycle
//     up        : 1 = increment, 0 = decrement
//     term_val  : value at which term is raised
//     term      : current count equals term_val
module pc_flow_wait_cnt #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             en,
   input  logic             up,
   input  logic [WIDTH-1:0] term_val,
   output logic             term
);

   logic [WIDTH-1:0] cnt_q;
   logic [WIDTH-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = load_val;
      end else if (en) begin
         cnt_d = up ? cnt_q + WIDTH'(1) : cnt_q - WIDTH'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign term = (cnt_q == term_val);

endmodule

// File: rtl/pc_flow_ctrl.sv
// pc_flow_ctrl
//   Pipeline flow controller sequencing the program counter. Arbitrates EX
//   redirects (JAL, JALR, taken branch), ID load-use stalls and multi-cycle
//   accelerator instructions; drives the PC load enable / next value and the
//   IF/ID, ID/EX flush and stall controls.
//   Ports:
//     clk  : clock, rising edge
//     rst  : synchronous reset, active-high
//     bus  : pc_flow_ctrl_if.slave (hazard inputs, PC / pipeline controls)
//   Parameters: XLEN, RESET_PC, FLUSH_CYCLES (1..3), ACC_TIMEOUT
module pc_flow_ctrl
   import pc_flow_ctrl_pkg::*;
#(
   parameter int              XLEN         = 32,
   parameter logic [XLEN-1:0] RESET_PC     = '0,
   parameter int              FLUSH_CYCLES = 2,
   parameter int              ACC_TIMEOUT  = 1024
) (
   input logic              clk,
   input logic              rst,
   pc_flow_ctrl_if.slave    bus
);

   localparam int FCW = 2;
   localparam int WCW = $clog2(ACC_TIMEOUT + 1);

   localparam logic [FCW-1:0] FLUSH_LOAD = FCW'(FLUSH_CYCLES - 1);
   localparam logic [WCW-1:0] WAIT_TERM  = WCW'(ACC_TIMEOUT - 1);

   state_e state_q, state_d;
   logic   boot_q, boot_d;
   logic   timeout_q, timeout_d;

   logic   f_load, f_en, f_term;
   logic   w_load, w_en, w_term;

   logic            pc_we;
   logic [XLEN-1:0] pc_next;
   logic            flush_ifid;
   logic            flush_idex;
   logic            stall_ifid;
   logic            acc_busy;

   logic            jump_hit;
   logic [XLEN-1:0] jump_pc;
   logic [XLEN-1:0] seq_pc;

   // Flush counter: loaded with FLUSH_CYCLES-1 on a redirect and counted down
   // in FLUSH. The redirect cycle itself is the first bubble, so FLUSH is left
   // once the counter sits at 1 (its last decrement lands on 0).
   pc_flow_wait_cnt #(.WIDTH(FCW)) u_flush_cnt (
      .clk      (clk),
      .rst      (rst),
      .load     (f_load),
      .load_val (FLUSH_LOAD),
      .en       (f_en),
      .up       (funDisable),
      .term_val (FCW'(1)),
      .term     (f_term)
   );

   // Accelerator wait counter: cleared on entry and counted up every
   // ACC_WAIT cycle; terminal at ACC_TIMEOUT-1 forces a release.
   pc_flow_wait_cnt #(.WIDTH(WCW)) u_wait_cnt (
      .clk      (clk),
      .rst      (rst),
      .load     (w_load),
      .load_val ('0),
      .en       (w_en),
      .up       (funEnable),
      .term_val (WAIT_TERM),
      .term     (w_term)
   );

   // Jump decode: encoding 11 is treated as no jump; JALR drops bit 0.
   always_comb begin
      jump_hit = 1'b0;
      jump_pc  = bus.jal_target;
      case (bus.jump)
         JUMP_JAL: begin
            jump_hit = 1'b1;
            jump_pc  = bus.jal_target;
         end
         JUMP_JALR: begin
            jump_hit = 1'b1;
            jump_pc  = bus.jalr_target & ~XLEN'(1);
         end
         default: begin
            jump_hit = 1'b0;
         end
      endcase
   end

   assign seq_pc = bus.cur_pc + XLEN'(4);

   // Next-state and output logic. boot_q marks the first cycle after reset,
   // in which the PC is forced to RESET_PC regardless of the hazard inputs.
   always_comb begin
      state_d    = state_q;
      boot_d     = 1'b0;
      timeout_d  = timeout_q;
      pc_we      = 1'b0;
      pc_next    = seq_pc;
      flush_ifid = 1'b0;
      flush_idex = 1'b0;
      stall_ifid = 1'b0;
      acc_busy   = 1'b0;
      f_load     = funDisable;
      f_en       = funDisable;
      w_load     = funDisable;
      w_en       = funDisable;

      if (boot_q) begin
         pc_we   = 1'b1;
         pc_next = RESET_PC;
         state_d = RUN;
      end else begin
         unique case (state_q)
            RUN: begin
               if (jump_hit || (bus.branch && bus.zero)) begin
                  pc_we      = 1'b1;
                  pc_next    = jump_hit ? jump_pc : bus.br_target;
                  flush_ifid = 1'b1;
                  flush_idex = 1'b1;
                  f_load     = funEnable;
                  if (FLUSH_CYCLES > 1) begin
                     state_d = FLUSH;
                  end
               end else if (bus.acc_start) begin
                  stall_ifid = 1'b1;
                  flush_idex = 1'b1;
                  w_load     = funEnable;
                  state_d    = ACC_WAIT;
               end else if (bus.ld_use) begin
                  stall_ifid = 1'b1;
                  flush_idex = 1'b1;
               end else begin
                  pc_we = 1'b1;
               end
            end
            FLUSH: begin
               pc_we      = 1'b1;
               flush_ifid = 1'b1;
               flush_idex = 1'b1;
               f_en       = funEnable;
               if (f_term) begin
                  state_d = RUN;
               end
            end
            ACC_WAIT: begin
               acc_busy   = 1'b1;
               stall_ifid = 1'b1;
               flush_idex = 1'b1;
               w_en       = funEnable;
               if (bus.acc_done) begin
                  state_d = RUN;
               end else if (w_term) begin
                  timeout_d = 1'b1;
                  state_d   = RUN;
               end
            end
            default: begin
               state_d = RUN;
            end
         endcase
      end
   end

   // State registers; reset returns to RUN and arms the boot cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= RUN;
         boot_q    <= 1'b1;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         boot_q    <= boot_d;
         timeout_q <= timeout_d;
      end
   end

   assign bus.pc_we       = pc_we;
   assign bus.pc_next     = pc_next;
   assign bus.flush_ifid  = flush_ifid;
   assign bus.flush_idex  = flush_idex;
   assign bus.stall_ifid  = stall_ifid;
   assign bus.acc_busy    = acc_busy;
   assign bus.acc_timeout = timeout_q;

endmodule
